// File: rtl/return_addr_stack_if.sv
// Signal bundle between fetch and the return-address stack.
// Optional push_cnt/pop_cnt exist only when RAS_STATS_EN is defined.
interface return_addr_stack_if #(
  parameter int AW = 32
);
  // push/pop are single-cycle strobes taken on the rising edge when stall is low.
  // There is no back-pressure: every unstalled strobe is accepted that cycle.
  logic          stall;
  logic          push;
  logic [AW-1:0] push_addr;
  logic          pop;
  logic [AW-1:0] ret_addr;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
`ifdef RAS_STATS_EN
  logic [15:0]   push_cnt;
  logic [15:0]   pop_cnt;
`endif

  modport master (
    output stall, push, push_addr, pop,
    input  ret_addr, empty, full, overflow, underflow
`ifdef RAS_STATS_EN
    , input push_cnt, pop_cnt
`endif
  );

  modport slave (
    input  stall, push, push_addr, pop,
    output ret_addr, empty, full, overflow, underflow
`ifdef RAS_STATS_EN
    , output push_cnt, pop_cnt
`endif
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack feeding the fetch PC mux; overflow drops the oldest entry.
// Define RAS_STATS_EN to add saturating push/pop counters.
module return_addr_stack #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  return_addr_stack_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] tos_q, tos_d;
  logic [PW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          we;
  logic [PW-1:0] waddr;
  logic          do_push, do_pop, is_empty, is_full;

  assign do_push  = bus.push & ~bus.stall;
  assign do_pop   = bus.pop  & ~bus.stall;
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);

  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    we          = 1'b0;
    waddr       = tos_q;
    if (do_push && do_pop && !is_empty) begin
      // Return immediately followed by a call: the top entry is replaced in place.
      we    = 1'b1;
      waddr = tos_q;
    end else if (do_push) begin
      we    = 1'b1;
      tos_d = tos_q + ONE_PTR;
      waddr = tos_q + ONE_PTR;
      if (is_full) overflow_d = 1'b1;
      else         count_d    = count_q + 1'b1;
    end else if (do_pop) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        tos_d   = tos_q - ONE_PTR;
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we) mem_q[waddr] <= bus.push_addr;
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.ret_addr  = is_empty ? '0 : mem_q[tos_q];
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef RAS_STATS_EN
  logic [15:0] push_cnt_q, push_cnt_d;
  logic [15:0] pop_cnt_q, pop_cnt_d;

  always_comb begin
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q;
    if (do_push && push_cnt_q != 16'hFFFF) push_cnt_d = push_cnt_q + 16'd1;
    if (do_pop  && pop_cnt_q  != 16'hFFFF) pop_cnt_d  = pop_cnt_q  + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
    end else begin
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  assign bus.push_cnt = push_cnt_q;
  assign bus.pop_cnt  = pop_cnt_q;
`endif
endmodule
